// File: rtl/dcls_fault_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcls_fault_ctrl
// Purpose  : Fault handling and configuration control for the dual-core
//            lockstep comparator. Owns the lockstep delay setting, blanks
//            comparison while the delayed core realigns, debounces the
//            comparator mismatch into transient / persistent faults, runs a
//            bounded number of core-reset recoveries and then latches a
//            sticky safe state.
// Ports    : clk, rst_n              - clock, async active-low reset
//            cfg_delay/valid/ready   - delay configuration handshake
//            error, error_vector     - comparator mismatch inputs
//            delay_sel               - lockstep delay to the comparator
//            core_rst_req            - reset request to both cores
//            fault_transient         - pulse: mismatch cleared before confirm
//            fault_permanent         - sticky: retries exhausted
//            safe_state              - sticky: system must go safe
//            err_count, err_signals  - error log outputs
// Options  : DCLS_ERR_LOG_EN - when defined, err_count / err_signals are
//            built; otherwise both are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module dcls_fault_ctrl #(
  parameter int NUM_SIGNALS    = 4,
  parameter int PERSIST_CYCLES = 3,
  parameter int RECOVER_CYCLES = 8,
  parameter int MAX_RETRIES    = 2,
  parameter int CLEAN_CYCLES   = 64,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             cfg_delay,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   error,
  input  logic [NUM_SIGNALS-1:0] error_vector,
  output logic [1:0]             delay_sel,
  output logic                   core_rst_req,
  output logic                   fault_transient,
  output logic                   fault_permanent,
  output logic                   safe_state,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic [NUM_SIGNALS-1:0] err_signals
);

  localparam int PW = $clog2(PERSIST_CYCLES + 1);
  localparam int RC = $clog2(RECOVER_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam int CW = $clog2(CLEAN_CYCLES + 1);

  localparam logic [PW-1:0] PERSIST_LAST = PW'(PERSIST_CYCLES - 1);
  localparam logic [RC-1:0] RECOVER_LAST = RC'(RECOVER_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);
  localparam logic [CW-1:0] CLEAN_LAST   = CW'(CLEAN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_RECOVER = 3'd2,
    ST_BLANK   = 3'd3,
    ST_SAFE    = 3'd4
  } state_t;

  state_t          state;
  logic [PW-1:0]   persist_cnt;
  logic [RC-1:0]   recover_cnt;
  logic [RW-1:0]   retry_cnt;
  logic [CW-1:0]   clean_cnt;
  logic [2:0]      blank_cnt;

  // Error has priority over configuration: no handshake while mismatching.
  assign cfg_ready = (state == ST_RUN) && !error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_RUN;
      persist_cnt     <= '0;
      recover_cnt     <= '0;
      retry_cnt       <= '0;
      clean_cnt       <= '0;
      blank_cnt       <= '0;
      delay_sel       <= 2'd0;
      core_rst_req    <= 1'b0;
      fault_transient <= 1'b0;
      fault_permanent <= 1'b0;
      safe_state      <= 1'b0;
    end else begin
      fault_transient <= 1'b0;
      case (state)
        ST_RUN: begin
          if (error) begin
            state       <= ST_CONFIRM;
            persist_cnt <= PW'(1);
            clean_cnt   <= '0;
          end else if (cfg_valid) begin
            delay_sel <= cfg_delay;
            blank_cnt <= '0;
            clean_cnt <= '0;
            state     <= ST_BLANK;
          end else if (clean_cnt == CLEAN_LAST) begin
            // Counter holds at its last value; every further clean cycle
            // keeps the retry budget fully restored.
            retry_cnt <= '0;
          end else begin
            clean_cnt <= clean_cnt + CW'(1);
          end
        end

        ST_CONFIRM: begin
          if (error) begin
            if (persist_cnt == PERSIST_LAST) begin
              if (retry_cnt < RETRY_MAX) begin
                retry_cnt    <= retry_cnt + RW'(1);
                recover_cnt  <= '0;
                core_rst_req <= 1'b1;
                state        <= ST_RECOVER;
              end else begin
                safe_state      <= 1'b1;
                fault_permanent <= 1'b1;
                state           <= ST_SAFE;
              end
            end else begin
              persist_cnt <= persist_cnt + PW'(1);
            end
          end else begin
            fault_transient <= 1'b1;
            state           <= ST_RUN;
          end
        end

        ST_RECOVER: begin
          // core_rst_req was raised on entry, so it spans RECOVER_CYCLES
          // cycles when dropped on the RECOVER_LAST count.
          if (recover_cnt == RECOVER_LAST) begin
            core_rst_req <= 1'b0;
            blank_cnt    <= '0;
            state        <= ST_BLANK;
          end else begin
            recover_cnt <= recover_cnt + RC'(1);
          end
        end

        ST_BLANK: begin
          clean_cnt <= '0;
          if (blank_cnt == ({1'b0, delay_sel} + 3'd1)) begin
            state <= ST_RUN;
          end else begin
            blank_cnt <= blank_cnt + 3'd1;
          end
        end

        ST_SAFE: begin
          // Sticky until rst_n.
        end

        default: begin
          // Illegal encoding is treated as an unrecoverable fault.
          safe_state      <= 1'b1;
          fault_permanent <= 1'b1;
          core_rst_req    <= 1'b0;
          state           <= ST_SAFE;
        end
      endcase
    end
  end

`ifdef DCLS_ERR_LOG_EN
  logic log_sample;
  logic log_transient;

  assign log_sample    = error && ((state == ST_RUN) || (state == ST_CONFIRM));
  assign log_transient = (state == ST_CONFIRM) && !error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count   <= '0;
      err_signals <= '0;
    end else begin
      if (log_sample) begin
        err_signals <= err_signals | error_vector;
      end
      if (log_transient && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end
`else
  logic unused_log_inputs;

  assign unused_log_inputs = ^error_vector;
  assign err_count         = '0;
  assign err_signals       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcls_fault_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcls_fault_ctrl
// Purpose  : Directed self-checking bench for dcls_fault_ctrl. Expected
//            values are queued when stimulus is applied and compared when
//            the design output is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcls_fault_ctrl;

`ifdef DCLS_ERR_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cfg_delay;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       error;
  logic [3:0] error_vector;
  logic [1:0] delay_sel;
  logic       core_rst_req;
  logic       fault_transient;
  logic       fault_permanent;
  logic       safe_state;
  logic [7:0] err_count;
  logic [3:0] err_signals;

  int errors = 0;
  int checks = 0;
  int model_delay = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dcls_fault_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_delay       (cfg_delay),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .error           (error),
    .error_vector    (error_vector),
    .delay_sel       (delay_sel),
    .core_rst_req    (core_rst_req),
    .fault_transient (fault_transient),
    .fault_permanent (fault_permanent),
    .safe_state      (safe_state),
    .err_count       (err_count),
    .err_signals     (err_signals)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Hold error for PERSIST_CYCLES sampled edges, then observe either a full
  // recovery (reset pulse + blanking) or entry into the safe state.
  task automatic persist_fault(input logic [3:0] vec, input logic expect_safe);
    int n;
    int b;
    error = 1'b1;
    error_vector = vec;
    step();
    step();
    push("rst_req_before_confirm", 0);
    pop_chk(32'(core_rst_req));
    step();
    error = 1'b0;
    error_vector = 4'h0;
    if (!expect_safe) begin
      push("rst_req_rise", 1);
      pop_chk(32'(core_rst_req));
      n = 0;
      while (core_rst_req === 1'b1 && n < 20) begin
        n++;
        step();
      end
      push("rst_req_len", 8);
      pop_chk(32'(n));
      b = 0;
      while (cfg_ready !== 1'b1 && b < 20) begin
        b++;
        step();
      end
      push("blank_len", 32'(model_delay + 2));
      pop_chk(32'(b));
    end else begin
      push("safe_state_set", 1);
      push("fault_perm_set", 1);
      push("safe_no_rst_req", 0);
      pop_chk(32'(safe_state));
      pop_chk(32'(fault_permanent));
      pop_chk(32'(core_rst_req));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    rst_n = 1'b0;
    cfg_delay = 2'd0;
    cfg_valid = 1'b0;
    error = 1'b0;
    error_vector = 4'h0;
    repeat (2) step();

    // Reset state
    push("rst_delay_sel", 0);
    push("rst_core_rst_req", 0);
    push("rst_fault_transient", 0);
    push("rst_fault_permanent", 0);
    push("rst_safe_state", 0);
    push("rst_err_count", 0);
    push("rst_err_signals", 0);
    pop_chk(32'(delay_sel));
    pop_chk(32'(core_rst_req));
    pop_chk(32'(fault_transient));
    pop_chk(32'(fault_permanent));
    pop_chk(32'(safe_state));
    pop_chk(32'(err_count));
    pop_chk(32'(err_signals));
    rst_n = 1'b1;
    step();

    // Configuration handshake, delay 2
    cfg_delay = 2'd2;
    cfg_valid = 1'b1;
    model_delay = 2;
    #1;
    push("cfg_ready_run", 1);
    pop_chk(32'(cfg_ready));
    step();
    cfg_valid = 1'b0;
    push("delay_sel_update", 2);
    pop_chk(32'(delay_sel));

    // Blanking: error forced high must be ignored for 4 cycles
    error = 1'b1;
    error_vector = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      push("blank_no_transient", 0);
      push("blank_no_rst_req", 0);
      pop_chk(32'(fault_transient));
      pop_chk(32'(core_rst_req));
    end
    error = 1'b0;
    #1;
    push("blank_cfg_ready_low", 0);
    pop_chk(32'(cfg_ready));
    error = 1'b1;
    step();
    error = 1'b0;
    error_vector = 4'h0;
    #1;
    push("run_after_blank", 1);
    push("blank_no_log", 0);
    pop_chk(32'(cfg_ready));
    pop_chk(32'(err_signals));

    // Transient fault
    error = 1'b1;
    error_vector = 4'b0010;
    step();
    error = 1'b0;
    error_vector = 4'h0;
    push("confirm_no_pulse_yet", 0);
    push("confirm_cfg_ready", 0);
    pop_chk(32'(fault_transient));
    pop_chk(32'(cfg_ready));
    step();
    push("transient_pulse", 1);
    push("err_count_one", LOG ? 1 : 0);
    push("err_signals_0010", LOG ? 4'b0010 : 0);
    push("transient_no_rst_req", 0);
    pop_chk(32'(fault_transient));
    pop_chk(32'(err_count));
    pop_chk(32'(err_signals));
    pop_chk(32'(core_rst_req));
    step();
    push("transient_one_cycle", 0);
    pop_chk(32'(fault_transient));

    // Persistent fault A -> recovery, retries = 1
    persist_fault(4'b0100, 1'b0);
    push("err_signals_0110", LOG ? 4'b0110 : 0);
    pop_chk(32'(err_signals));

    // 70 clean RUN cycles restore the retry budget
    repeat (70) step();

    // B and C recover, D enters SAFE
    persist_fault(4'b0001, 1'b0);
    persist_fault(4'b0001, 1'b0);
    persist_fault(4'b1000, 1'b1);

    cfg_valid = 1'b1;
    cfg_delay = 2'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      push("safe_cfg_ready", 0);
      push("safe_sticky", 1);
      push("safe_delay_kept", 2);
      pop_chk(32'(cfg_ready));
      pop_chk(32'(safe_state));
      pop_chk(32'(delay_sel));
    end
    push("err_signals_all", LOG ? 4'hF : 0);
    push("err_count_kept", LOG ? 1 : 0);
    pop_chk(32'(err_signals));
    pop_chk(32'(err_count));

    // Reset exits SAFE
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    push("safe_rst_safe_state", 0);
    push("safe_rst_perm", 0);
    pop_chk(32'(safe_state));
    pop_chk(32'(fault_permanent));
    rst_n = 1'b1;
    step();

    // Simultaneous error and cfg_valid: error wins, request held off
    cfg_delay = 2'd3;
    cfg_valid = 1'b1;
    error = 1'b1;
    error_vector = 4'b1000;
    #1;
    push("err_prio_cfg_ready", 0);
    pop_chk(32'(cfg_ready));
    step();
    push("err_prio_delay_kept", 0);
    pop_chk(32'(delay_sel));
    step();
    step();
    error = 1'b0;
    error_vector = 4'h0;
    push("recover_started", 1);
    pop_chk(32'(core_rst_req));
    repeat (3) step();

    // Asynchronous reset mid-RECOVER
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst_req_drop", 0);
    push("async_err_signals", 0);
    push("async_delay_sel", 0);
    push("async_state_run", 1);
    pop_chk(32'(core_rst_req));
    pop_chk(32'(err_signals));
    pop_chk(32'(delay_sel));
    pop_chk(32'(cfg_ready));
    rst_n = 1'b1;

    // Held request proceeds once RUN with no error
    step();
    cfg_valid = 1'b0;
    model_delay = 3;
    push("held_req_delay", 3);
    pop_chk(32'(delay_sel));
    b = 0;
    while (cfg_ready !== 1'b1 && b < 20) begin
      b++;
      step();
    end
    push("blank_len_d3", 32'(model_delay + 2));
    pop_chk(32'(b));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcls_fault_ctrl.md
# dcls_fault_ctrl

Fault-handling and configuration controller for the dual-core lockstep comparator (`dcls_top`). It owns the `delay_sel` setting and blanks comparison while the delayed core realigns. It debounces `error` to separate transient mismatches from persistent faults. Persistent faults trigger a bounded number of core-reset recovery attempts, then a sticky safe state.

## Interface
Parameters:
- `NUM_SIGNALS`, 4, width of `error_vector` (matches `dcls_top`)
- `PERSIST_CYCLES`, 3, consecutive sampled `error` cycles that confirm a persistent fault (>=2)
- `RECOVER_CYCLES`, 8, length of the `core_rst_req` pulse
- `MAX_RETRIES`, 2, recovery attempts before the safe state
- `CLEAN_CYCLES`, 64, consecutive error-free RUN cycles that clear the retry count
- `ERR_CNT_W`, 8, width of the transient error counter

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_delay`  in  2  requested lockstep delay for core1, 0..3 cycles
- `cfg_valid`  in  1  configuration request
- `cfg_ready`  out  1  request accepted this cycle when `cfg_valid & cfg_ready`
- `error`  in  1  comparator mismatch from `dcls_top`
- `error_vector`  in  NUM_SIGNALS  per-signal mismatch from `dcls_top`
- `delay_sel`  out  2  drives `dcls_top.delay_sel`
- `core_rst_req`  out  1  reset request to both lockstep cores
- `fault_transient`  out  1  one-cycle pulse when a mismatch clears before confirmation
- `fault_permanent`  out  1  sticky; retries exhausted
- `safe_state`  out  1  sticky; system must enter its safe state
- `err_count`  out  ERR_CNT_W  saturating count of transient faults
- `err_signals`  out  NUM_SIGNALS  sticky OR of every `error_vector` sampled with `error=1`

## Operation
- Reset values: state RUN, `delay_sel`=0, `core_rst_req`=0, `fault_transient`=0, `fault_permanent`=0, `safe_state`=0, `err_count`=0, `err_signals`=0. Internal counters are 0.
- **RUN**:
  - `cfg_ready` = `!error`; `error` has priority over a simultaneous `cfg_valid`.
  - `error`=1 -> CONFIRM with persist count 1.
  - Handshake -> `delay_sel` <= `cfg_delay`, then BLANK.
  - The clean counter increments on each error-free cycle; at `CLEAN_CYCLES` it clears the retry count.
- **CONFIRM**:
  - `error`=1 increments the persist count.
  - Reaching `PERSIST_CYCLES` with retries < `MAX_RETRIES` -> RECOVER and retries += 1.
  - Reaching `PERSIST_CYCLES` with retries = `MAX_RETRIES` -> SAFE.
  - `error`=0 -> RUN, `fault_transient` pulses, `err_count` += 1 (saturates at all-ones).
- **RECOVER**: `core_rst_req`=1 for exactly `RECOVER_CYCLES` cycles, then BLANK.
- **BLANK**: `error` is ignored for `delay_sel`+2 cycles, then RUN. The clean counter restarts at 0.
- **SAFE**: `safe_state`=1 and `fault_permanent`=1. `cfg_ready`=0 and all inputs are ignored. Only `rst_n` exits SAFE.
- `cfg_ready`=0 in every state except RUN. Requests outside RUN are held off, not dropped.
- `err_signals` ORs `error_vector` on every sampled `error`=1 in RUN and CONFIRM only.

## Timing
- `error` is sampled at edge N in RUN -> state CONFIRM after N.
- With `PERSIST_CYCLES`=3, `error` high at edges N, N+1, N+2 -> `core_rst_req` rises after edge N+2 and stays high for 8 cycles.
- `fault_transient` is high for the single cycle after the edge that samples `error`=0 in CONFIRM.
- A config handshake at edge M -> `delay_sel` is updated after M. BLANK lasts `cfg_delay`+2 cycles and RUN resumes after that.
- Registered outputs: `delay_sel`, `core_rst_req`, `fault_*`, `safe_state`, `err_*`. `cfg_ready` is combinational from state and `error`.
- An `rst_n` assertion in any state forces the reset values immediately, including mid-RECOVER (`core_rst_req` drops asynchronously).

## Configuration
- Macro: `DCLS_ERR_LOG_EN`.
- Defined: `err_count` and `err_signals` operate as specified.
- Undefined: both outputs are tied to 0 and their registers are not built. FSM behaviour is unchanged.

## Test plan
- Reset then `cfg_delay`=2 with `cfg_valid`:
  - `cfg_ready`=1, `delay_sel`=2 next cycle.
  - BLANK for 4 cycles with `error` forced high -> no state change and no `fault_transient`.
- `error` high 1 cycle with `error_vector`=4'b0010 in RUN:
  - `fault_transient` pulse.
  - `err_count`=1, `err_signals`=4'b0010, no `core_rst_req`.
- `error` held high 3 cycles:
  - `core_rst_req` high for exactly 8 cycles.
  - BLANK for `delay_sel`+2 cycles, then RUN.
- Three persistent faults back-to-back, under 64 clean cycles apart:
  - Two RECOVER sequences, then `safe_state`=1 and `fault_permanent`=1.
  - `cfg_ready`=0 and remains so until `rst_n`.
- Two persistent faults separated by 64 clean RUN cycles -> both recover and there is no SAFE.
- Simultaneous `error`=1 and `cfg_valid`=1 in RUN:
  - `cfg_ready`=0 and `delay_sel` unchanged.
  - `rst_n` pulled low mid-RECOVER clears all outputs to their reset values.
